// File: rtl/iiitb_rv32i.sv
// iiitb_rv32i: compact 5-stage (IF, ID, EX, MEM, WB) in-order RV32I core.
// Instruction ROM, register file and data RAM are internal; only the fetch
// PC and the last register write-back value are observable.
module iiitb_rv32i #(
  parameter int          IMEM_WORDS = 32,
  parameter int          DMEM_WORDS = 32,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          PROG_LEN   = 12,
  parameter logic [31:0] PROGRAM [PROG_LEN] = '{
    32'h00208333, 32'h402083B3, 32'h0030F433, 32'h005164B3,
    32'h0040C533, 32'h004125B3, 32'h00520613, 32'h00502623,
    32'h00C02683, 32'h00209733, 32'h001257B3, 32'h00000063
  }
) (
  input  logic        clk,
  input  logic        RN,
  output logic [31:0] NPC,
  output logic [31:0] WB_OUT
);
  localparam int          IA  = $clog2(IMEM_WORDS);
  localparam int          DA  = $clog2(DMEM_WORDS);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {K_NOP, K_ALU_R, K_ALU_I, K_LOAD, K_STORE, K_BRANCH} kind_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } if_id_t;

  typedef struct packed {
    kind_t       kind;
    logic [2:0]  f3;
    logic        alt;   // instr[30]: selects SUB over ADD
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] pc;
  } id_ex_t;

  typedef struct packed {
    logic        wr;
    logic        load;
    logic        store;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] sdata;
  } ex_mem_t;

  typedef struct packed {
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] data;
  } mem_wb_t;

  localparam id_ex_t ID_NOP = '{kind: K_NOP, default: '0};

  function automatic logic [31:0][31:0] reg_ramp();
    logic [31:0][31:0] r;
    for (int i = 0; i < 32; i++) r[i] = 32'(i);
    return r;
  endfunction

  function automatic logic [DMEM_WORDS-1:0][31:0] dm_ramp();
    logic [DMEM_WORDS-1:0][31:0] r;
    for (int i = 0; i < DMEM_WORDS; i++) r[i] = 32'(i);
    return r;
  endfunction

  // NOTE: register file and data RAM must come out of reset holding a ramp,
  // so they are flat packed vectors loaded in one assignment, not RAM macros.
  logic [31:0][31:0]           regs;
  logic [DMEM_WORDS-1:0][31:0] dm;

  if_id_t  if_id;
  id_ex_t  id_ex, id_next;
  ex_mem_t ex_mem;
  mem_wb_t mem_wb;

  // Instruction ROM: program words first, NOP everywhere else.
  logic [31:0] rom [IMEM_WORDS];
  for (genvar g = 0; g < IMEM_WORDS; g++) begin : g_rom
    if (g < PROG_LEN) begin : g_prog
      assign rom[g] = PROGRAM[g];
    end else begin : g_nop
      assign rom[g] = NOP;
    end
  end

  logic [31:0] fetch_instr;
  assign fetch_instr = rom[NPC[IA+1:2]];

  // Decode: classify the instruction, read operands, build the immediate.
  logic [4:0]  rs1, rs2;
  logic [2:0]  id_f3;
  logic [31:0] ins;
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    ins          = if_id.instr;
    rs1          = ins[19:15];
    rs2          = ins[24:20];
    id_f3        = ins[14:12];
    id_next      = ID_NOP;
    id_next.f3   = id_f3;
    id_next.alt  = ins[30];
    id_next.rd   = ins[11:7];
    id_next.a    = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    id_next.b    = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
    id_next.pc   = if_id.pc;
    case (ins[6:0])
      7'b0110011: if (id_f3 != 3'd3) id_next.kind = K_ALU_R;
      7'b0010011: if (id_f3 inside {3'd0, 3'd2, 3'd4, 3'd6, 3'd7}) begin
        id_next.kind = K_ALU_I;
        id_next.imm  = {{20{ins[31]}}, ins[31:20]};
      end
      7'b0000011: if (id_f3 == 3'd2) begin
        id_next.kind = K_LOAD;
        id_next.imm  = {{20{ins[31]}}, ins[31:20]};
      end
      7'b0100011: if (id_f3 == 3'd2) begin
        id_next.kind = K_STORE;
        id_next.imm  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      7'b1100011: if (id_f3 inside {3'd0, 3'd1}) begin
        id_next.kind = K_BRANCH;
        id_next.imm  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      default: ;
    endcase
  end

  // Execute: ALU result or memory address, and branch resolution.
  logic [31:0] opb, alu, target;
  logic        taken;
  always_comb begin
    opb = (id_ex.kind == K_ALU_R) ? id_ex.b : id_ex.imm;
    case (id_ex.f3)
      3'd0:    alu = (id_ex.kind == K_ALU_R && id_ex.alt) ? id_ex.a - opb : id_ex.a + opb;
      3'd1:    alu = id_ex.a << opb[4:0];
      3'd2:    alu = {31'd0, $signed(id_ex.a) < $signed(opb)};
      3'd4:    alu = id_ex.a ^ opb;
      3'd5:    alu = id_ex.a >> opb[4:0];
      3'd6:    alu = id_ex.a | opb;
      3'd7:    alu = id_ex.a & opb;
      default: alu = id_ex.a + opb;
    endcase
    if (id_ex.kind inside {K_LOAD, K_STORE}) alu = id_ex.a + id_ex.imm;
    taken  = (id_ex.kind == K_BRANCH) &&
             (id_ex.f3[0] ? (id_ex.a != id_ex.b) : (id_ex.a == id_ex.b));
    target = id_ex.pc + id_ex.imm;
  end

  logic [DA-1:0] dm_idx;
  assign dm_idx = ex_mem.alu[DA+1:2];

  // Pipeline advance, memory access and write-back, with synchronous reset.
  // NOTE: all state here uses non-blocking assignments so every stage sees
  // the values its predecessor held before this edge.
  always_ff @(posedge clk) begin
    if (RN) begin
      NPC    <= RESET_PC;
      WB_OUT <= 32'd0;
      if_id  <= '{instr: NOP, pc: 32'd0};
      id_ex  <= ID_NOP;
      ex_mem <= '0;
      mem_wb <= '0;
      regs   <= reg_ramp();
      dm     <= dm_ramp();
    end else begin
      if (taken) begin
        NPC   <= target;
        if_id <= '{instr: NOP, pc: 32'd0};
        id_ex <= ID_NOP;
      end else begin
        NPC   <= NPC + 32'd4;
        if_id <= '{instr: fetch_instr, pc: NPC};
        id_ex <= id_next;
      end
      ex_mem <= '{wr:    id_ex.kind inside {K_ALU_R, K_ALU_I, K_LOAD},
                  load:  id_ex.kind == K_LOAD,
                  store: id_ex.kind == K_STORE,
                  rd:    id_ex.rd,
                  alu:   alu,
                  sdata: id_ex.b};
      if (ex_mem.store) dm[dm_idx] <= ex_mem.sdata;
      mem_wb <= '{wr:   ex_mem.wr,
                  rd:   ex_mem.rd,
                  data: ex_mem.load ? dm[dm_idx] : ex_mem.alu};
      if (mem_wb.wr && mem_wb.rd != 5'd0) begin
        regs[mem_wb.rd] <= mem_wb.data;
        WB_OUT          <= mem_wb.data;
      end
    end
  end
endmodule

// File: tb/tb_iiitb_rv32i.sv
// Testbench for iiitb_rv32i: an instruction-level model (architectural
// state updated at fetch, visible write-back delayed by four edges, taken
// branches squash two fetch slots) checked against NPC/WB_OUT every edge,
// plus literal expectations for the default program and random resets.
module tb_iiitb_rv32i;
  logic        clk = 1'b0;
  logic        rn  = 1'b1;
  logic [31:0] npc, wb_out, npc_x0, wb_out_x0;
  int          checks = 0;
  int          errors = 0;

  localparam logic [31:0] ALT_PROG [12] = '{
    32'h00700013, 32'h402083B3, 32'h0030F433, 32'h005164B3,
    32'h00100333, 32'h004125B3, 32'h00520613, 32'h00502623,
    32'h00C02683, 32'h00209733, 32'h001257B3, 32'h00000063
  };
  localparam logic [31:0] WB_SEQ [11] = '{
    32'h3, 32'hFFFFFFFF, 32'h1, 32'h7, 32'h5, 32'h1, 32'h9, 32'h9, 32'h5, 32'h4, 32'h2
  };

  // Default program as listed for the core (ADD..SRL, BEQ self-loop).
  logic [31:0] prog [32] = '{
    0: 32'h00208333, 1: 32'h402083B3, 2: 32'h0030F433, 3: 32'h005164B3,
    4: 32'h0040C533, 5: 32'h004125B3, 6: 32'h00520613, 7: 32'h00502623,
    8: 32'h00C02683, 9: 32'h00209733, 10: 32'h001257B3, 11: 32'h00000063,
    default: 32'h00000013
  };

  always #5 clk = ~clk;

  iiitb_rv32i dut (.clk(clk), .RN(rn), .NPC(npc), .WB_OUT(wb_out));
  iiitb_rv32i #(.PROGRAM(ALT_PROG)) dut_x0 (.clk(clk), .RN(rn), .NPC(npc_x0), .WB_OUT(wb_out_x0));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %08h expected %08h", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_reg [32];
  logic [31:0] m_dm  [32];
  logic [31:0] m_npc, m_wb, m_target;
  int          squash, edge_n;
  bit          p_valid [8];
  logic [31:0] p_val   [8];

  task automatic model_exec(input logic [31:0] ins, input logic [31:0] pc);
    logic [2:0]  f3;
    logic [31:0] a, b, imm_i, imm_s, imm_b, res, addr;
    int          rd, slot;
    bit          wr;
    f3    = ins[14:12];
    rd    = int'(ins[11:7]);
    a     = m_reg[ins[19:15]];
    b     = m_reg[ins[24:20]];
    imm_i = 32'($signed(ins[31:20]));
    imm_s = 32'($signed({ins[31:25], ins[11:7]}));
    imm_b = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    wr    = 0;
    res   = 32'd0;
    case (ins[6:0])
      7'h33: begin
        wr = 1;
        case (f3)
          3'd0: res = ins[30] ? a - b : a + b;
          3'd1: res = a << b[4:0];
          3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3'd4: res = a ^ b;
          3'd5: res = a >> b[4:0];
          3'd6: res = a | b;
          3'd7: res = a & b;
          default: wr = 0;
        endcase
      end
      7'h13: begin
        wr = 1;
        case (f3)
          3'd0: res = a + imm_i;
          3'd2: res = ($signed(a) < $signed(imm_i)) ? 32'd1 : 32'd0;
          3'd4: res = a ^ imm_i;
          3'd6: res = a | imm_i;
          3'd7: res = a & imm_i;
          default: wr = 0;
        endcase
      end
      7'h03: if (f3 == 3'd2) begin
        addr = a + imm_i;
        res  = m_dm[addr[6:2]];
        wr   = 1;
      end
      7'h23: if (f3 == 3'd2) begin
        addr = a + imm_s;
        m_dm[addr[6:2]] = b;
      end
      7'h63: if ((f3 == 3'd0 && a == b) || (f3 == 3'd1 && a != b)) begin
        squash   = 2;
        m_target = pc + imm_b;
      end
      default: ;
    endcase
    if (wr && rd != 0) begin
      m_reg[rd]     = res;
      slot          = (edge_n + 4) % 8;
      p_valid[slot] = 1;
      p_val[slot]   = res;
    end
  endtask

  task automatic model_edge(input logic r);
    int          slot;
    logic [31:0] pc;
    if (r) begin
      m_npc  = 32'h0;
      m_wb   = 32'h0;
      squash = 0;
      edge_n = 0;
      for (int i = 0; i < 32; i++) begin
        m_reg[i] = 32'(i);
        m_dm[i]  = 32'(i);
      end
      for (int i = 0; i < 8; i++) p_valid[i] = 0;
    end else begin
      edge_n++;
      slot = edge_n % 8;
      if (p_valid[slot]) begin
        m_wb          = p_val[slot];
        p_valid[slot] = 0;
      end
      if (squash == 2) begin
        squash = 1;
        m_npc  = m_npc + 32'd4;
      end else if (squash == 1) begin
        squash = 0;
        m_npc  = m_target;
      end else begin
        pc    = m_npc;
        m_npc = m_npc + 32'd4;
        model_exec(prog[pc[6:2]], pc);
      end
    end
  endtask

  // Compare process: advance the model on every edge and check 1 time unit later.
  initial begin
    forever begin
      @(posedge clk);
      model_edge(rn);
      #1;
      check("npc", npc, m_npc);
      check("wb_out", wb_out, m_wb);
      check("npc_x0", npc_x0, m_npc);
    end
  end

  // Runs n edges after a reset release, checking hand-computed values.
  task automatic run_pinned(input int n);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #2;
      case (k)
        1:  check("npc_e1", npc, 32'h4);
        2:  check("npc_e2", npc, 32'h8);
        3:  check("npc_e3", npc, 32'hC);
        11: check("npc_e11", npc, 32'h2C);
        12: check("npc_e12", npc, 32'h30);
        13: check("npc_e13", npc, 32'h34);
        14: check("npc_e14", npc, 32'h2C);
        20: check("wb_hold_e20", wb_out, 32'h2);
        default: ;
      endcase
      if (k >= 5 && k <= 15) check($sformatf("wb_seq_e%0d", k), wb_out, WB_SEQ[k-5]);
      if (k == 5) check("x0_write_dropped", wb_out_x0, 32'h0);
      if (k == 9) check("x0_read_zero", wb_out_x0, 32'h1);
    end
    @(negedge clk);
  endtask

  task automatic check_state();
    for (int i = 0; i < 32; i++) begin
      check($sformatf("reg_x%0d", i), dut.regs[i], m_reg[i]);
      check($sformatf("dm_%0d", i), dut.dm[i], m_dm[i]);
    end
  endtask

  // Stimulus: reset, default program, mid-run reset, then random resets.
  initial begin
    rn = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("reset_npc", npc, 32'h0);
    check("reset_wb", wb_out, 32'h0);
    @(negedge clk);
    rn = 1'b0;
    run_pinned(20);
    check("x6_add", dut.regs[6], 32'h3);
    check("x12_addi", dut.regs[12], 32'h9);
    check("dm3_store", dut.dm[3], 32'h5);
    check_state();

    // Fresh start, then a one-edge reset at edge 9.
    rn = 1'b1;
    @(negedge clk);
    rn = 1'b0;
    run_pinned(8);
    rn = 1'b1;
    @(posedge clk);
    #2;
    check("midreset_npc", npc, 32'h0);
    check("midreset_wb", wb_out, 32'h0);
    check("midreset_x6", dut.regs[6], 32'h6);
    @(negedge clk);
    rn = 1'b0;
    run_pinned(16);
    check_state();

    // Random reset pulses of random length at random points in the program.
    for (int it = 0; it < 30; it++) begin
      rn = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rn = 1'b0;
      repeat ($urandom_range(1, 40)) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    check_state();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/iiitb_rv32i.md
Name: iiitb_rv32i

Overview:
- Compact 5-stage (IF, ID, EX, MEM, WB) in-order RV32I integer pipeline.
- Instruction ROM, 32x32 register file and data RAM are all internal.
- Exposes only the fetch PC (NPC) and the write-back data (WB_OUT) as observation ports.
- Used as the top-level demonstration core; no external bus.

Parameters:
- IMEM_WORDS, 32, instruction ROM depth in 32-bit words; unlisted locations hold NOP 0x00000013.
- DMEM_WORDS, 32, data RAM depth in 32-bit words.
- RESET_PC, 32'h0, fetch address after reset.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- RN  input  1  synchronous, active-high reset.
- NPC  output  32  current fetch PC (byte address presented to the instruction ROM), registered.
- WB_OUT  output  32  last value written to the register file, registered.

Behaviour:
- Reset (RN=1 at a rising edge):
  - NPC=RESET_PC and WB_OUT=0.
  - All pipeline registers are cleared to NOP.
  - REG[i]=i for i=0..31; DM[i]=i.
  - Reset takes effect mid-run identically.
- Fetch: each edge IF/ID <= ROM[NPC[6:2]] and NPC <= NPC+4. With no branches, NPC=4k after the k-th edge following reset release.
- Supported instructions use standard RV32I encodings:
  - R-type: ADD, SUB, AND, OR, XOR, SLT (signed), SLL, SRL (shift amount rs2[4:0]).
  - I-type: ADDI, ANDI, ORI, XORI, SLTI.
  - Memory: LW, SW.
  - Branch: BEQ, BNE.
  - Any other opcode executes as a NOP.
- Immediates are sign-extended. Arithmetic is 32-bit modulo; SUB wraps.
- Memory addressing: effective address = rs1 + imm; data word index = address[6:2]; low two bits are ignored. SW writes in MEM; LW data is returned in MEM and written back in WB.
- Branch:
  - Resolved in EX; target = branch PC + B-immediate.
  - If taken: NPC <= target at the next edge, and IF/ID and ID/EX are flushed to NOP at the same edge.
  - If not taken: no effect.
- Hazards: no forwarding and no interlock. Software must space dependent instructions by at least 3 intervening instructions. The register file writes on the edge; a same-cycle read returns the old value.
- Write-back latency: the instruction fetched at edge n writes REG[rd] and WB_OUT at edge n+4.
- WB_OUT holds its value for instructions with no register write (SW, branches, NOPs).
- Writes to x0 are discarded and WB_OUT is not updated for them; x0 always reads 0.
- Default ROM program (rd=result with reset register contents):
  - 0x00 ADD x6,x1,x2 (=3)
  - 0x04 SUB x7,x1,x2 (=0xFFFFFFFF)
  - 0x08 AND x8,x1,x3 (=1)
  - 0x0C OR x9,x2,x5 (=7)
  - 0x10 XOR x10,x1,x4 (=5)
  - 0x14 SLT x11,x2,x4 (=1)
  - 0x18 ADDI x12,x4,5 (=9)
  - 0x1C SW x5,12(x0) (DM[3]=5)
  - 0x20 LW x13,12(x0) (=5)
  - 0x24 SLL x14,x1,x2 (=4)
  - 0x28 SRL x15,x4,x1 (=2)
  - 0x2C BEQ x0,x0,0 (self-loop)
  - rest NOP

Test Plan:
- Reset: hold RN=1 for 2 edges -> NPC=0x0, WB_OUT=0; release RN -> NPC=0x4, 0x8, 0xC on the next three edges.
- ALU sequence, edges counted after release: WB_OUT = 3, 0xFFFFFFFF, 1, 7, 5, 1, 9 after edges 5 through 11; x6..x12 hold those values.
- Store/load: WB_OUT stays 9 after edge 12 (SW), then is 5 after edge 13 (LW reads DM[3]=5); then 4 after edge 14 and 2 after edge 15.
- Branch loop and flush: NPC = 0x2C after edge 11, 0x30, 0x34, then 0x2C after edge 14, repeating 0x2C/0x30/0x34 forever. WB_OUT stays 2 from edge 15 on, because the flushed slots never write.
- Mid-run reset: assert RN for one edge at edge 9 -> NPC=0, WB_OUT=0, registers re-initialised; the WB_OUT sequence restarts exactly as in the ALU-sequence scenario.
- x0 protection: replace ROM[0] with ADDI x0,x0,7 -> WB_OUT stays 0 after edge 5, and a later ADD x6,x0,x1 writes 1.
